// File: rtl/aes_dec_pkg.sv
// Shared AES-128 decryption helpers: S-box tables, Rcon, FSM state type,
// GF(2^8) arithmetic and the word/state transforms used by the core.
package aes_dec_pkg;

   typedef enum logic [1:0] {IDLE, KEYEXP, ROUND} state_e;

   localparam logic [7:0] SBOX [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
      8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
      8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
      8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
      8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
      8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
      8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
      8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
      8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
      8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
      8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
      8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
      8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
      8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
      8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
      8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d};

   // Rcon[1..10]; any other index yields zero so out-of-phase lookups stay benign.
   function automatic logic [7:0] rcon(input logic [3:0] n);
      case (n)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   // Byte i of the state lives at bits [127-8i -: 8], column-major (row = i%4).
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         {a0, a1, a2, a3} = s[127-32*c -: 32];
         o[127-32*c -: 32] = {
            gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09),
            gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d),
            gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b),
            gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e)};
      end
      return o;
   endfunction

   function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      w0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h0};
      w1 = k[95:64] ^ w0;
      w2 = k[63:32] ^ w1;
      w3 = k[31:0]  ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // Undo one schedule step: recover rk[r-1] from rk[r] using Rcon[r].
   function automatic logic [127:0] key_bwd(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      w3 = k[31:0]  ^ k[63:32];
      w2 = k[63:32] ^ k[95:64];
      w1 = k[95:64] ^ k[127:96];
      w0 = k[127:96] ^ sub_word(rot_word(w3)) ^ {rc, 24'h0};
      return {w0, w1, w2, w3};
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round; the final round skips InvMixColumns.
module aes_inv_round
   import aes_dec_pkg::*;
(
   input  logic [127:0] data_i,
   input  logic [127:0] round_key_i,
   input  logic         last_i,
   output logic [127:0] data_o
);

   logic [127:0] keyed;

   assign keyed  = inv_sub_bytes(inv_shift_rows(data_i)) ^ round_key_i;
   assign data_o = last_i ? keyed : inv_mix_columns(keyed);

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 decryption core: 10 forward key-schedule cycles, then 10
// inverse rounds with on-the-fly backward key regeneration.
// Optional AES_DEC_KEY_CACHE_EN keeps the last rk10 so a repeated key skips KEYEXP.
module aes_decrypt_core
   import aes_dec_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] ciphertext,
   input  logic [127:0] cipher_key,
   output logic [127:0] plaintext,
   output logic         busy,
   output logic         done
);

   state_e       state_q;
   logic [3:0]   cnt_q;
   logic [127:0] data_q, key_q, ct_q, plaintext_q;
   logic         busy_q, done_q;
   logic [127:0] rk_fwd, rk_bwd, round_out;

`ifdef AES_DEC_KEY_CACHE_EN
   logic         cache_valid_q;
   logic [127:0] cache_key_q, cache_rk10_q;
`endif

   // In ROUND r the register holds rk[r+1]; the round consumes rk[r].
   assign rk_fwd = key_fwd(key_q, rcon(cnt_q));
   assign rk_bwd = key_bwd(key_q, rcon(4'(cnt_q + 4'd1)));

   aes_inv_round u_inv_round (
      .data_i      (data_q),
      .round_key_i (rk_bwd),
      .last_i      (cnt_q == 4'd0),
      .data_o      (round_out)
   );

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         data_q      <= '0;
         key_q       <= '0;
         ct_q        <= '0;
         plaintext_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
         // NOTE: cached key/rk10 need no reset; the valid flag alone gates their use.
         cache_valid_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  ct_q   <= ciphertext;
                  key_q  <= cipher_key;
                  busy_q <= 1'b1;
`ifdef AES_DEC_KEY_CACHE_EN
                  if (cache_valid_q && (cipher_key == cache_key_q)) begin
                     data_q  <= ciphertext ^ cache_rk10_q;
                     key_q   <= cache_rk10_q;
                     cnt_q   <= 4'd9;
                     state_q <= ROUND;
                  end else begin
                     cache_key_q   <= cipher_key;
                     cache_valid_q <= 1'b0;
                     cnt_q         <= 4'd1;
                     state_q       <= KEYEXP;
                  end
`else
                  cnt_q   <= 4'd1;
                  state_q <= KEYEXP;
`endif
               end
            end
            KEYEXP: begin
               key_q <= rk_fwd;
               if (cnt_q == 4'd10) begin
                  data_q  <= ct_q ^ rk_fwd;
                  cnt_q   <= 4'd9;
                  state_q <= ROUND;
`ifdef AES_DEC_KEY_CACHE_EN
                  cache_rk10_q  <= rk_fwd;
                  cache_valid_q <= 1'b1;
`endif
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            ROUND: begin
               data_q <= round_out;
               key_q  <= rk_bwd;
               if (cnt_q == 4'd0) begin
                  plaintext_q <= round_out;
                  done_q      <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign plaintext = plaintext_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Self-checking bench for aes_decrypt_core against a textbook AES-128 inverse
// cipher model; latency expectations follow AES_DEC_KEY_CACHE_EN when defined.
module tb_aes_decrypt_core;

`ifdef AES_DEC_KEY_CACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst, start;
   logic [127:0] ciphertext, cipher_key, plaintext;
   logic         busy, done;

   int total = 0;
   int bad   = 0;

   logic [7:0]   sb [256];
   logic [7:0]   isb [256];
   bit           m_valid;
   logic [127:0] m_key;

   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   always #5 clk = ~clk;

   aes_decrypt_core dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .ciphertext (ciphertext),
      .cipher_key (cipher_key),
      .plaintext  (plaintext),
      .busy       (busy),
      .done       (done)
   );

   // ---------------- reference model ----------------
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? (8'(x << 1) ^ 8'h1b) : 8'(x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      return 8'((b << n) | (b >> (8 - n)));
   endfunction

   // S-box from its definition: multiplicative inverse followed by the affine map.
   task automatic build_tables();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv, s;
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
         sb[x]  = s;
         isb[s] = 8'(x);
      end
   endtask

   function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input logic [127:0] key);
      logic [31:0]  w [44];
      logic [7:0]   st [16];
      logic [7:0]   tmp [16];
      logic [7:0]   rc, a0, a1, a2, a3;
      logic [31:0]  t;
      logic [127:0] res;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
            rc = gf_mul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int b = 0; b < 16; b++) st[b] = ct[127-8*b -: 8] ^ w[40 + b/4][31-8*(b%4) -: 8];
      for (int rnd = 9; rnd >= 0; rnd--) begin
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) tmp[r+4*c] = st[r+4*((c+4-r)%4)];
         for (int b = 0; b < 16; b++) st[b] = isb[tmp[b]] ^ w[4*rnd + b/4][31-8*(b%4) -: 8];
         if (rnd > 0) begin
            for (int c = 0; c < 4; c++) begin
               a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
               st[4*c]   = gf_mul(a0,8'h0e)^gf_mul(a1,8'h0b)^gf_mul(a2,8'h0d)^gf_mul(a3,8'h09);
               st[4*c+1] = gf_mul(a0,8'h09)^gf_mul(a1,8'h0e)^gf_mul(a2,8'h0b)^gf_mul(a3,8'h0d);
               st[4*c+2] = gf_mul(a0,8'h0d)^gf_mul(a1,8'h09)^gf_mul(a2,8'h0e)^gf_mul(a3,8'h0b);
               st[4*c+3] = gf_mul(a0,8'h0b)^gf_mul(a1,8'h0d)^gf_mul(a2,8'h09)^gf_mul(a3,8'h0e);
            end
         end
      end
      for (int b = 0; b < 16; b++) res[127-8*b -: 8] = st[b];
      return res;
   endfunction

   function automatic int exp_lat(input logic [127:0] key);
      return (CACHE && m_valid && (key == m_key)) ? 10 : 20;
   endfunction

   task automatic note_done(input logic [127:0] key);
      m_valid = 1'b1;
      m_key   = key;
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- stimulus driver ----------------
   // Called at a negedge; returns at the negedge where done is seen (or after 40 cycles).
   task automatic run_block(input logic [127:0] ct, input logic [127:0] key, input int poke_at,
                            output logic [127:0] pt, output int lat, output int busy_low);
      ciphertext = ct;
      cipher_key = key;
      start      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start      = 1'b0;
      ciphertext = rand128();
      cipher_key = rand128();
      lat        = 0;
      busy_low   = 0;
      pt         = '0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (cyc == poke_at) begin
            start      = 1'b1;
            ciphertext = rand128();
            cipher_key = rand128();
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
         if (done) begin
            lat = cyc;
            pt  = plaintext;
            break;
         end
         if (!busy) busy_low++;
      end
      start = 1'b0;
   endtask

   task automatic count_dones(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) n++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; start = 1'b0; ciphertext = '0; cipher_key = '0;
      m_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
      total++; if (plaintext !== 128'h0) begin bad++; $display("FAIL reset_pt: got %h want 0", plaintext); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_vectors();
      logic [127:0] cts [3], keys [3], pts [3];
      logic [127:0] pt;
      int lat, bl, el;
      cts  = '{C1_CT, B_CT, Z_CT};
      keys = '{C1_KEY, B_KEY, 128'h0};
      pts  = '{C1_PT, B_PT, 128'h0};
      for (int i = 0; i < 3; i++) begin
         el = exp_lat(keys[i]);
         run_block(cts[i], keys[i], -1, pt, lat, bl);
         note_done(keys[i]);
         total++; if (pt !== pts[i]) begin bad++; $display("FAIL vec%0d_pt: got %h want %h", i, pt, pts[i]); end
         total++; if (lat != el) begin bad++; $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, el); end
         total++; if (bl != 0) begin bad++; $display("FAIL vec%0d_busy: busy low %0d cycles want 0", i, bl); end
         @(negedge clk);
         total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL vec%0d_idle: busy,done=%b want 00", i, {busy, done}); end
         total++; if (plaintext !== pts[i]) begin bad++; $display("FAIL vec%0d_hold: got %h want %h", i, plaintext, pts[i]); end
      end
   endtask

   task automatic test_random();
      logic [127:0] ct, key, pt, ex;
      int lat, bl, el;
      key = rand128();
      for (int i = 0; i < 6; i++) begin
         ct = rand128();
         if (i % 2 == 0) key = rand128();
         ex = ref_decrypt(ct, key);
         el = exp_lat(key);
         run_block(ct, key, -1, pt, lat, bl);
         note_done(key);
         total++; if (pt !== ex) begin bad++; $display("FAIL rand%0d_pt: got %h want %h", i, pt, ex); end
         total++; if (lat != el) begin bad++; $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, el); end
         @(negedge clk);
      end
   endtask

   task automatic test_ignore_start();
      logic [127:0] pt;
      int lat, bl, el, extra;
      el = exp_lat(C1_KEY);
      run_block(C1_CT, C1_KEY, 5, pt, lat, bl);
      note_done(C1_KEY);
      total++; if (pt !== C1_PT) begin bad++; $display("FAIL ignore_pt: got %h want %h", pt, C1_PT); end
      total++; if (lat != el) begin bad++; $display("FAIL ignore_latency: got %0d want %0d", lat, el); end
      count_dones(30, extra);
      total++; if (extra != 0) begin bad++; $display("FAIL ignore_extra_done: got %0d want 0", extra); end
   endtask

   task automatic test_reset_mid();
      logic [127:0] pt;
      int lat, bl, n;
      ciphertext = C1_CT; cipher_key = C1_KEY; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (12) begin @(posedge clk); @(negedge clk); end
      rst = 1'b1;
      m_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL midrst_flags: busy,done=%b want 00", {busy, done}); end
      total++; if (plaintext !== 128'h0) begin bad++; $display("FAIL midrst_pt: got %h want 0", plaintext); end
      count_dones(30, n);
      total++; if (n != 0) begin bad++; $display("FAIL midrst_no_done: got %0d want 0", n); end
      run_block(C1_CT, C1_KEY, -1, pt, lat, bl);
      note_done(C1_KEY);
      total++; if (pt !== C1_PT) begin bad++; $display("FAIL midrst_restart_pt: got %h want %h", pt, C1_PT); end
      total++; if (lat != 20) begin bad++; $display("FAIL midrst_restart_latency: got %0d want 20", lat); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [127:0] ct_a, ct_b, key_a, key_b, pt_a, pt_b;
      int lat_a, lat_b, bl, el_a, el_b;
      ct_a = rand128(); key_a = rand128();
      ct_b = rand128(); key_b = rand128();
      el_a = exp_lat(key_a);
      run_block(ct_a, key_a, -1, pt_a, lat_a, bl);
      note_done(key_a);
      el_b = exp_lat(key_b);
      run_block(ct_b, key_b, -1, pt_b, lat_b, bl);
      note_done(key_b);
      total++; if (pt_a !== ref_decrypt(ct_a, key_a)) begin bad++; $display("FAIL b2b_a_pt: got %h want %h", pt_a, ref_decrypt(ct_a, key_a)); end
      total++; if (lat_a != el_a) begin bad++; $display("FAIL b2b_a_latency: got %0d want %0d", lat_a, el_a); end
      total++; if (pt_b !== ref_decrypt(ct_b, key_b)) begin bad++; $display("FAIL b2b_b_pt: got %h want %h", pt_b, ref_decrypt(ct_b, key_b)); end
      total++; if (lat_b != el_b) begin bad++; $display("FAIL b2b_b_latency: got %0d want %0d", lat_b, el_b); end
      @(negedge clk);
   endtask

   task automatic test_key_cache();
      logic [127:0] pt, ex, k2;
      int lat, bl, el;
      run_block(C1_CT, C1_KEY, -1, pt, lat, bl);
      note_done(C1_KEY);
      @(negedge clk);
      ex = ref_decrypt(B_CT, C1_KEY);
      el = exp_lat(C1_KEY);
      run_block(B_CT, C1_KEY, -1, pt, lat, bl);
      note_done(C1_KEY);
      total++; if (pt !== ex) begin bad++; $display("FAIL cache_hit_pt: got %h want %h", pt, ex); end
      total++; if (lat != el) begin bad++; $display("FAIL cache_hit_latency: got %0d want %0d", lat, el); end
      total++; if (bl != 0) begin bad++; $display("FAIL cache_hit_busy: busy low %0d cycles want 0", bl); end
      @(negedge clk);
      k2 = C1_KEY ^ 128'h1;
      ex = ref_decrypt(B_CT, k2);
      el = exp_lat(k2);
      run_block(B_CT, k2, -1, pt, lat, bl);
      note_done(k2);
      total++; if (pt !== ex) begin bad++; $display("FAIL cache_miss_pt: got %h want %h", pt, ex); end
      total++; if (lat != el) begin bad++; $display("FAIL cache_miss_latency: got %0d want %0d", lat, el); end
      @(negedge clk);
   endtask

   initial begin
      build_tables();
      test_reset();
      test_vectors();
      test_random();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      test_key_cache();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/aes_decrypt_core.md
Name: aes_decrypt_core

Overview:
Iterative AES-128 (FIPS-197) decryption engine. It computes one inverse round per clock and regenerates round keys on the fly from the 128-bit cipher key. It sits beside the encryption core in the AES datapath and takes a single 128-bit block per start pulse. It uses a start/busy/done handshake.

Parameters:
None. Key size is fixed at 128 bits and round count at 10.

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  reset; synchronous, active-high
start  input  1  request; sampled only in IDLE
ciphertext  input  128  input block, byte 0 = bits [127:120]
cipher_key  input  128  AES-128 key, same byte order
plaintext  output  128  decrypted block
busy  output  1  high while a block is in flight
done  output  1  one-cycle pulse when plaintext becomes valid

Behaviour:
- Reset (rst=1 at a clock edge): state←IDLE; plaintext, busy, done ←0; round counter ←0. Reset mid-operation aborts the block; no done pulse follows.
- States: IDLE, KEYEXP, ROUND.
- IDLE: start=1 latches ciphertext and cipher_key, sets counter ←1, busy ←1, state ←KEYEXP. ciphertext and cipher_key may change after the start edge.
- KEYEXP (counters 1..10): each cycle computes rk[n] from rk[n-1] with the standard forward schedule (RotWord, SubWord, Rcon[n]).
  - On the n=10 edge, data register ← latched ciphertext XOR rk10, and state ←ROUND with counter r=9.
- ROUND (r=9..0): data ← InvMixColumns(InvSubBytes(InvShiftRows(data)) XOR rk[r]). For r=0, InvMixColumns is omitted.
- Key register steps backward each ROUND cycle. From rk[r]=(w0,w1,w2,w3), rk[r-1] is built as follows:
  - w3'=w3^w2
  - w2'=w2^w1
  - w1'=w1^w0
  - w0'=w0^SubWord(RotWord(w3'))^Rcon[r]
- On the r=0 edge: plaintext ← result, done ←1 for exactly one cycle, busy ←0, state ←IDLE.
- Latency: the start-sampling edge is edge 0. done is high after edge 20, i.e. 20 cycles start-to-done.
- plaintext holds its value until the next completed block or reset.
- start while busy is ignored. It is not queued.
- start may be high in the cycle done is high. IDLE accepts it on the following edge, so back-to-back throughput is one block per 21 cycles.
- GF(2^8) multiplication uses reduction polynomial 0x11B. InvMixColumns coefficients are 0e, 0b, 0d, 09.
- Fully combinational S-box/inverse S-box lookups. No RAMs.

Optional Feature:
Macro AES_DEC_KEY_CACHE_EN.
- Defined:
  - The core keeps the last expanded key and its rk10, with a valid flag cleared by reset.
  - On start, if the valid flag is set and cipher_key equals the cached key, KEYEXP is skipped. That edge loads data ← ciphertext XOR cached rk10 and enters ROUND at r=9, so done is high after edge 10.
  - A miss behaves as normal and refreshes the cache at KEYEXP n=10.
- Undefined: no cache storage. Latency is always 20.

Decomposition:
- Package aes_dec_pkg holds:
  - forward S-box and inverse S-box constant tables
  - Rcon[1..10]
  - state enum (IDLE, KEYEXP, ROUND)
  - functions xtime/gmul, SubWord, RotWord, InvShiftRows, InvMixColumns
- One combinational sub-module, aes_inv_round, is natural. Inputs: data, round key, last-round flag. Output: next data.

Test Plan:
- FIPS-197 C.1: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, key 000102030405060708090a0b0c0d0e0f → plaintext 00112233445566778899aabbccddeeff, done high 20 cycles after start, busy high throughout.
- FIPS-197 App. B: ciphertext 3925841d02dc09fbdc118597196a0b32, key 2b7e151628aed2a6abf7158809cf4f3c → plaintext 3243f6a8885a308d313198a2e0370734.
- Zero key: ciphertext 66e94bd4ef8a2c3b884cfa59ca342b2e, key 0 → plaintext 0.
- Second start pulse at cycle 5 of a block → ignored. Single done, correct C.1 result. Inputs changed after the start edge do not affect the result.
- rst asserted at cycle 12 → next cycle busy=0, done=0, plaintext=0, no done pulse afterwards. A fresh C.1 start then completes correctly.
- With AES_DEC_KEY_CACHE_EN: run C.1, then the App. B ciphertext under the C.1 key → done after 10 cycles. Expected plaintext computed by the reference model: plaintext of 3925841d02dc09fbdc118597196a0b32 under key 000102…0f. A changed key → 20 cycles.
